seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial-pattern detector, the next generation of the fixed 5-bit Moore detector: detects a run-time programmable PAT_LEN-bit pattern on a single-bit serial input. Overlapping or non-overlapping matching is selectable, and input-qualify and match-count features are added. It sits in the serial front-end, sampling the line bit-by-bit, and flags matches to downstream control logic with a Moore-style registered output.

## Interface
- PAT_LEN, 5: pattern length in bits; legal range 2..32.
- PAT_RST, 5'b00010: pattern value after reset; first-received bit is the MSB, so the default is the sequence 0,0,0,1,0.
- CNT_W, 8: match counter width.
- clk  in  1  single clock; all logic on the rising edge.
- nres  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- INP  in  1  serial data bit; sampled only when in_valid=1.
- in_valid  in  1  qualifies INP; when 0, no state changes except cfg/clear handling.
- cfg_pattern  in  PAT_LEN  new pattern; MSB is the first expected bit.
- cfg_mode  in  1  0 = overlapping, 1 = non-overlapping; latched with cfg_load.
- cfg_load  in  1  one-cycle pulse; latches cfg_pattern and cfg_mode, then flushes history.
- clear  in  1  synchronous clear of match_cnt and cnt_sat.
- OUTP  out  1  Moore match flag; high for one cycle per detected match.
- match_cnt  out  CNT_W  number of matches, saturating at all-ones.
- cnt_sat  out  1  sticky; set when a match occurs while match_cnt is already all-ones.

## Operation
- State registers:
  - pat_q (PAT_LEN bits).
  - mode_q.
  - hist (PAT_LEN-bit shift register of received bits; newest bit in the LSB).
  - fill (0..PAT_LEN, the number of valid history bits).
  - match_q, which drives OUTP.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist_n = {hist[PAT_LEN-2:0], INP}.
  - fill_n = min(fill+1, PAT_LEN).
  - hit = (fill_n == PAT_LEN) && (hist_n == pat_q).
- On hit:
  - match_q <= 1.
  - match_cnt increments unless already all-ones; otherwise cnt_sat <= 1.
  - Overlap mode: fill stays PAT_LEN, so a pattern suffix can start the next match.
  - Non-overlap mode: fill <= 0 and hist <= 0, so the next match needs PAT_LEN fresh bits.
- No hit, or in_valid=0: match_q <= 0. With in_valid=0, hist and fill hold.
- cfg_load=1:
  - pat_q <= cfg_pattern, mode_q <= cfg_mode, hist <= 0, fill <= 0, match_q <= 0.
  - The INP bit in the same cycle is discarded even if in_valid=1.
  - match_cnt is untouched.
- clear=1: match_cnt <= 0 and cnt_sat <= 0. If a hit occurs in the same cycle, clear wins: the count is 0, not 1. OUTP is still asserted for that hit.
- Reset values: pat_q=PAT_RST, mode_q=0 (overlap), hist=0, fill=0, OUTP=0, match_cnt=0, cnt_sat=0.
- Reset asserted mid-stream discards all partial history immediately, asynchronously.

## Timing
- Bit accepted at rising edge k; OUTP is high during cycle k+1 (after edge k) and low after edge k+1 unless edge k+1 also hits.
- match_cnt reflects the hit in the same cycle that OUTP is high.
- Back-to-back hits, e.g. pattern all-ones in overlap mode, keep OUTP high on consecutive cycles.
- First possible hit after reset or cfg_load is on the PAT_LEN-th accepted bit.
- OUTP is driven only from a flop; there is no combinational path from INP to OUTP.

## Structure
- Package seq_det_pkg holds:
  - typedef enum logic {MODE_OVERLAP=1'b0, MODE_NONOVERLAP=1'b1} det_mode_t.
  - Localparam defaults for PAT_LEN, PAT_RST and CNT_W.
- Sub-module sat_counter (parameter W; ports clk, nres, inc, clr, cnt, sat) implements the saturating counter and sticky flag, with clr priority over inc.
- The detector core (history, fill, compare, mode handling) lives in seq_detector_param.

## Test plan
- Default config, overlap: stream 0,0,0,1,0,0,0,1,0 → OUTP high exactly after bits 5 and 9; match_cnt=2.
- Same stream with cfg_load of pattern 5'b00010, cfg_mode=1 → hits after bits 5 and 10 for stream 0,0,0,1,0,0,0,0,1,0; with 0,0,0,1,0,0,0,1,0 only one hit.
- in_valid gaps: insert in_valid=0 cycles with garbage INP inside a match → hit is unaffected and delayed only by the gap length.
- Pattern 5'b11111, overlap, 8 consecutive ones → OUTP high for 4 consecutive cycles; match_cnt=4.
- CNT_W=2, 5 hits → match_cnt=3, cnt_sat=1; clear concurrent with a 6th hit → match_cnt=0, cnt_sat=0, OUTP=1.
- Async reset after 4 matching bits, then release; cfg_load applied mid-pattern → no hit until PAT_LEN new bits have been accepted; all outputs 0 during reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial pattern detector.
package seq_det_pkg;

   typedef enum logic {MODE_OVERLAP = 1'b0, MODE_NONOVERLAP = 1'b1} det_mode_t;

   localparam int         DEF_PAT_LEN = 5;
   localparam logic [4:0] DEF_PAT_RST = 5'b00010;
   localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nres,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   logic [W-1:0] r_cnt;
   logic         r_sat;

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (clr) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (inc) begin
         // At all-ones the count holds and the overflow is remembered instead
         if (&r_cnt) r_sat <= 1'b1;
         else        r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;
   assign sat = r_sat;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable PAT_LEN-bit serial pattern detector with overlap / non-overlap
// matching, input qualify and a saturating match counter; OUTP is registered.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PAT_RST = DEF_PAT_RST,
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               nres,
   input  logic               INP,
   input  logic               in_valid,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_mode,
   input  logic               cfg_load,
   input  logic               clear,
   output logic               OUTP,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam int FW = $clog2(PAT_LEN + 1);

   logic [PAT_LEN-1:0] r_pat;
   logic [PAT_LEN-1:0] r_hist;
   logic [FW-1:0]      r_fill;
   det_mode_t          r_mode;
   logic               r_match;

   logic               w_accept;
   logic [PAT_LEN-1:0] w_hist_n;
   logic [FW-1:0]      w_fill_n;
   logic               w_hit;

   // A configuration load takes priority and swallows the bit of that cycle
   always_comb begin
      w_accept = in_valid & ~cfg_load;
      w_hist_n = {r_hist[PAT_LEN-2:0], INP};
      w_fill_n = (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + 1'b1;
      w_hit    = w_accept && (w_fill_n == FW'(PAT_LEN)) && (w_hist_n == r_pat);
   end

   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         r_pat   <= PAT_RST;
         r_mode  <= MODE_OVERLAP;
         r_hist  <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
      end else if (cfg_load) begin
         r_pat   <= cfg_pattern;
         r_mode  <= det_mode_t'(cfg_mode);
         r_hist  <= '0;
         r_fill  <= '0;
         r_match <= 1'b0;
      end else if (w_accept) begin
         r_match <= w_hit;
         // Non-overlap restarts collection so the next match needs fresh bits
         if (w_hit && (r_mode == MODE_NONOVERLAP)) begin
            r_hist <= '0;
            r_fill <= '0;
         end else begin
            r_hist <= w_hist_n;
            r_fill <= w_fill_n;
         end
      end else begin
         r_match <= 1'b0;
      end
   end

   assign OUTP = r_match;

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk  (clk),
      .nres (nres),
      .inc  (w_hit),
      .clr  (clear),
      .cnt  (match_cnt),
      .sat  (cnt_sat)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: vector table, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_seq_detector_param;
   import seq_det_pkg::*;

   localparam int PL = 5;

   logic          clk = 1'b0;
   logic          nres;
   logic          inp, vld, cfg_load, cfg_mode, clr;
   logic [PL-1:0] cfg_pat;
   logic          outp8, outp2, sat8, sat2;
   logic [7:0]    cnt8;
   logic [1:0]    cnt2;

   always #5 clk = ~clk;

   seq_detector_param #(.PAT_LEN(PL), .PAT_RST(5'b00010), .CNT_W(8)) dut8 (
      .clk(clk), .nres(nres), .INP(inp), .in_valid(vld), .cfg_pattern(cfg_pat),
      .cfg_mode(cfg_mode), .cfg_load(cfg_load), .clear(clr),
      .OUTP(outp8), .match_cnt(cnt8), .cnt_sat(sat8));

   seq_detector_param #(.PAT_LEN(PL), .PAT_RST(5'b00010), .CNT_W(2)) dut2 (
      .clk(clk), .nres(nres), .INP(inp), .in_valid(vld), .cfg_pattern(cfg_pat),
      .cfg_mode(cfg_mode), .cfg_load(cfg_load), .clear(clr),
      .OUTP(outp2), .match_cnt(cnt2), .cnt_sat(sat2));

   int nvec  = 0;
   int nfail = 0;
   int hits  = 0;

   // Reference model: the accepted bits since the last flush, kept as a queue
   bit            mq[$];
   logic [PL-1:0] m_pat;
   bit            m_mode, m_outp, m_sat8, m_sat2;
   int            m_cnt8, m_cnt2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pat  = 5'b00010;
      m_mode = 1'b0;
      m_outp = 1'b0;
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
   endtask

   task automatic model_step();
      bit            hit;
      logic [PL-1:0] v;
      hit = 1'b0;
      if (cfg_load) begin
         m_pat  = cfg_pat;
         m_mode = cfg_mode;
         mq.delete();
      end else if (vld) begin
         mq.push_back(inp);
         if (mq.size() > PL) void'(mq.pop_front());
         if (mq.size() == PL) begin
            v = '0;
            foreach (mq[i]) v = {v[PL-2:0], mq[i]};
            hit = (v == m_pat);
         end
         if (hit && m_mode) mq.delete();
      end
      m_outp = hit;
      if (clr) begin
         m_cnt8 = 0; m_sat8 = 1'b0;
         m_cnt2 = 0; m_sat2 = 1'b0;
      end else if (hit) begin
         if (m_cnt8 == 255) m_sat8 = 1'b1; else m_cnt8++;
         if (m_cnt2 == 3)   m_sat2 = 1'b1; else m_cnt2++;
      end
   endtask

   // Apply one cycle, then compare both instances with the model after the edge
   task automatic step(input logic i, input logic v);
      inp = i;
      vld = v;
      @(posedge clk);
      model_step();
      #1;
      cfg_load = 1'b0;
      clr      = 1'b0;
      if (outp8 === 1'b1) hits++;
      check("OUTP",         32'(outp8), 32'(m_outp));
      check("match_cnt",    32'(cnt8),  32'(m_cnt8));
      check("cnt_sat",      32'(sat8),  32'(m_sat8));
      check("OUTP_w2",      32'(outp2), 32'(m_outp));
      check("match_cnt_w2", 32'(cnt2),  32'(m_cnt2));
      check("cnt_sat_w2",   32'(sat2),  32'(m_sat2));
   endtask

   task automatic load(input logic [PL-1:0] p, input logic m);
      cfg_pat  = p;
      cfg_mode = m;
      cfg_load = 1'b1;
      step(1'b1, 1'b1);
   endtask

   task automatic send(input logic [15:0] bits, input int n);
      for (int k = n - 1; k >= 0; k--) step(bits[k], 1'b1);
   endtask

   typedef struct {
      logic       inp;
      logic       vld;
      logic       outp;
      logic [7:0] cnt;
   } vec_t;

   vec_t       tbl[9];
   logic [7:0] seqv;

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b0, 8'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 8'd0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 8'd0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd1};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 8'd1};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 8'd1};
      tbl[7] = '{1'b1, 1'b1, 1'b0, 8'd1};
      tbl[8] = '{1'b0, 1'b1, 1'b1, 8'd2};

      nres = 1'b0; inp = 1'b0; vld = 1'b0; cfg_load = 1'b0; clr = 1'b0;
      cfg_pat = '0; cfg_mode = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_OUTP", 32'(outp8), 32'd0);
      check("rst_cnt",  32'(cnt8),  32'd0);
      check("rst_sat",  32'(sat8),  32'd0);
      nres = 1'b1;

      // Default pattern, overlap mode
      for (int k = 0; k < 9; k++) begin
         step(tbl[k].inp, tbl[k].vld);
         check("tbl_OUTP", 32'(outp8), 32'(tbl[k].outp));
         check("tbl_cnt",  32'(cnt8),  32'(tbl[k].cnt));
      end

      // Non-overlap mode
      clr = 1'b1;
      load(5'b00010, 1'b1);
      hits = 0;
      send(16'b00_0100_0010, 10);
      check("nonovl_hits_a", 32'(hits), 32'd2);
      check("nonovl_cnt_a",  32'(cnt8), 32'd2);
      load(5'b00010, 1'b1);
      hits = 0;
      send(16'b0_0010_0010, 9);
      check("nonovl_hits_b", 32'(hits), 32'd1);
      check("nonovl_cnt_b",  32'(cnt8), 32'd3);

      // in_valid gap with garbage INP inside a match
      load(5'b00010, 1'b0);
      hits = 0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      repeat (3) step(1'($urandom), 1'b0);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check("gap_no_early", 32'(outp8), 32'd0);
      step(1'b0, 1'b1);
      check("gap_hit",  32'(outp8), 32'd1);
      check("gap_hits", 32'(hits),  32'd1);

      // All-ones pattern, back-to-back hits
      clr = 1'b1;
      load(5'b11111, 1'b0);
      seqv = '0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1);
         seqv[k] = outp8;
      end
      check("ones_outp_seq", 32'(seqv), 32'h0000_00f0);
      check("ones_cnt",      32'(cnt8), 32'd4);

      // Saturation on the 2-bit counter, then clear concurrent with a hit
      clr = 1'b1;
      load(5'b11111, 1'b0);
      repeat (9) step(1'b1, 1'b1);
      check("sat_cnt2", 32'(cnt2), 32'd3);
      check("sat_flag", 32'(sat2), 32'd1);
      check("sat_cnt8", 32'(cnt8), 32'd5);
      clr = 1'b1;
      step(1'b1, 1'b1);
      check("clr_hit_outp", 32'(outp8), 32'd1);
      check("clr_hit_cnt2", 32'(cnt2),  32'd0);
      check("clr_hit_sat2", 32'(sat2),  32'd0);

      // Async reset after four matching bits
      load(5'b00010, 1'b0);
      send(16'b0_0010, 5);
      send(16'b0001, 4);
      #3;
      nres = 1'b0;
      model_reset();
      #1;
      check("arst_OUTP", 32'(outp8), 32'd0);
      check("arst_cnt",  32'(cnt8),  32'd0);
      check("arst_sat",  32'(sat2),  32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("arst_hold_cnt", 32'(cnt8), 32'd0);
      nres = 1'b1;
      step(1'b0, 1'b1);
      check("arst_no_hit", 32'(outp8), 32'd0);
      send(16'b0010, 4);
      check("arst_fresh_hit", 32'(outp8), 32'd1);

      // cfg_load mid-pattern flushes history
      send(16'b0001, 4);
      load(5'b00010, 1'b0);
      step(1'b0, 1'b1);
      check("load_no_hit", 32'(outp8), 32'd0);
      send(16'b0010, 4);
      check("load_fresh_hit", 32'(outp8), 32'd1);

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(63) == 0) begin
            cfg_pat  = PL'($urandom);
            cfg_mode = 1'($urandom);
            cfg_load = 1'b1;
         end
         clr = ($urandom_range(49) == 0);
         step(1'($urandom), ($urandom_range(7) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
